pa_clic_arb_scan: RTL and testbench

//  Sequential CLIC interrupt arbiter, parametrised successor to the one-hot ID expander.
//  - Scans NUM pending sources GROUP per cycle.
//  - Tracks the highest-priority pending source above a threshold.
//  - Presents the winner as ID and priority behind a valid/ack handshake.
//  - Optionally presents the winner as a one-hot vector.
//  - Sits between the CLIC pending/priority registers and the core interrupt request logic.

---
 rtl/pa_clic_arb_scan_if.sv | 30 +++
 rtl/pa_clic_arb_scan.sv | 221 ++++++++++++++++++++++
 tb/tb_pa_clic_arb_scan.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pa_clic_arb_scan_if.sv
// Bundle for the CLIC arbiter request/result signals.
// The requesting side (CLIC registers plus core request logic) uses the master modport.
// The arbiter uses the slave modport.
// arb_onehot is always present; it only carries data when PA_CLIC_ARB_ONEHOT_EN is defined.
interface pa_clic_arb_scan_if #(
    parameter int NUM    = 64,
    parameter int ID_W   = 6,
    parameter int PRIO_W = 8
);
    logic                  arb_en;
    logic [NUM-1:0]        int_pend_vec;
    logic [PRIO_W*NUM-1:0] int_prio_vec;
    logic [PRIO_W-1:0]     int_thresh;
    logic                  arb_ack;
    logic                  arb_vld;
    logic [ID_W-1:0]       arb_id;
    logic [PRIO_W-1:0]     arb_prio;
    logic                  arb_busy;
    logic [NUM-1:0]        arb_onehot;

    modport master (
        output arb_en, int_pend_vec, int_prio_vec, int_thresh, arb_ack,
        input  arb_vld, arb_id, arb_prio, arb_busy, arb_onehot
    );

    modport slave (
        input  arb_en, int_pend_vec, int_prio_vec, int_thresh, arb_ack,
        output arb_vld, arb_id, arb_prio, arb_busy, arb_onehot
    );
endinterface

// File: rtl/pa_clic_arb_scan.sv
// pa_clic_arb_scan: sequential CLIC interrupt arbiter.
// The arbiter scans NUM pending sources, GROUP sources per cycle.
// It tracks the highest-priority pending source; ties go to the lowest index.
// When the winner's priority is strictly above int_thresh, the arbiter holds the winner
// behind a valid/ack handshake.
// Optional feature macro: PA_CLIC_ARB_ONEHOT_EN.
// When that macro is defined, the arbiter registers arb_onehot together with arb_id.
// Otherwise arb_onehot is tied to zero.
module pa_clic_arb_scan #(
    parameter int NUM    = 64,
    parameter int ID_W   = 6,
    parameter int PRIO_W = 8,
    parameter int GROUP  = 8
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    pa_clic_arb_scan_if.slave    bus
);
    localparam int SCAN_LEN = NUM / GROUP;
    localparam int CNT_W    = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
    localparam int SEL_W    = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    grp_cnt_r, grp_cnt_nxt_s;
    logic                best_vld_r, best_vld_nxt_s;
    logic [ID_W-1:0]     best_id_r, best_id_nxt_s;
    logic [PRIO_W-1:0]   best_prio_r, best_prio_nxt_s;
    logic                load_out_s;

    logic [PRIO_W-1:0]   prio_arr_s [NUM];
    logic                grp_vld_s;
    logic [ID_W-1:0]     grp_id_s;
    logic [PRIO_W-1:0]   grp_prio_s;
    logic                win_vld_s;
    logic [ID_W-1:0]     win_id_s;
    logic [PRIO_W-1:0]   win_prio_s;

    logic                arb_vld_r;
    logic                arb_busy_r;
    logic [ID_W-1:0]     arb_id_r;
    logic [PRIO_W-1:0]   arb_prio_r;

    // Unpack the flat priority bus into one entry per source.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            prio_arr_s[i] = bus.int_prio_vec[PRIO_W*i +: PRIO_W];
        end
    end

    // Pick the best candidate of the current group.
    // The candidate must beat best_* strictly, and a strict in-group compare keeps the lowest index on ties.
    always_comb begin
        logic [SEL_W-1:0]  src_v;
        logic [PRIO_W-1:0] p_v;
        grp_vld_s  = 1'b0;
        grp_id_s   = '0;
        grp_prio_s = '0;
        for (int j = 0; j < GROUP; j++) begin
            src_v = SEL_W'(int'(grp_cnt_r) * GROUP + j);
            p_v   = prio_arr_s[src_v];
            if (bus.int_pend_vec[src_v] &&
                (!best_vld_r || (p_v > best_prio_r)) &&
                (!grp_vld_s  || (p_v > grp_prio_s))) begin
                grp_vld_s  = 1'b1;
                grp_id_s   = ID_W'(src_v);
                grp_prio_s = p_v;
            end else begin
                grp_vld_s  = grp_vld_s;
            end
        end
    end

    // Merge the running best with this cycle's group contribution.
    always_comb begin
        win_vld_s = grp_vld_s | best_vld_r;
        if (grp_vld_s) begin
            win_id_s   = grp_id_s;
            win_prio_s = grp_prio_s;
        end else begin
            win_id_s   = best_id_r;
            win_prio_s = best_prio_r;
        end
    end

    // Compute the next state, the scan counter and the running best.
    always_comb begin
        state_nxt_s     = state_r;
        grp_cnt_nxt_s   = grp_cnt_r;
        best_vld_nxt_s  = best_vld_r;
        best_id_nxt_s   = best_id_r;
        best_prio_nxt_s = best_prio_r;
        load_out_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.arb_en) begin
                    state_nxt_s     = ST_SCAN;
                    grp_cnt_nxt_s   = '0;
                    best_vld_nxt_s  = 1'b0;
                    best_prio_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!bus.arb_en) begin
                    state_nxt_s     = ST_IDLE;
                    grp_cnt_nxt_s   = '0;
                    best_vld_nxt_s  = 1'b0;
                    best_prio_nxt_s = '0;
                end else if (grp_cnt_r == LAST_CNT) begin
                    grp_cnt_nxt_s = '0;
                    if (win_vld_s && (win_prio_s > bus.int_thresh)) begin
                        state_nxt_s     = ST_HOLD;
                        load_out_s      = 1'b1;
                        best_vld_nxt_s  = 1'b1;
                        best_id_nxt_s   = win_id_s;
                        best_prio_nxt_s = win_prio_s;
                    end else begin
                        state_nxt_s     = ST_IDLE;
                        best_vld_nxt_s  = 1'b0;
                        best_prio_nxt_s = '0;
                    end
                end else begin
                    grp_cnt_nxt_s = grp_cnt_r + CNT_W'(1);
                    if (grp_vld_s) begin
                        best_vld_nxt_s  = 1'b1;
                        best_id_nxt_s   = grp_id_s;
                        best_prio_nxt_s = grp_prio_s;
                    end else begin
                        best_vld_nxt_s = best_vld_r;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.arb_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                grp_cnt_nxt_s   = '0;
                best_vld_nxt_s  = 1'b0;
                best_prio_nxt_s = '0;
            end
        endcase
    end

    // Update the state, the scan counter and the running best registers.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_r     <= ST_IDLE;
            grp_cnt_r   <= '0;
            best_vld_r  <= 1'b0;
            best_id_r   <= '0;
            best_prio_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            grp_cnt_r   <= grp_cnt_nxt_s;
            best_vld_r  <= best_vld_nxt_s;
            best_id_r   <= best_id_nxt_s;
            best_prio_r <= best_prio_nxt_s;
        end
    end

    // Register the outputs.
    // vld and busy follow the next state; id/prio are captured on entry to HOLD and kept stable.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            arb_vld_r  <= 1'b0;
            arb_busy_r <= 1'b0;
            arb_id_r   <= '0;
            arb_prio_r <= '0;
        end else begin
            arb_vld_r  <= (state_nxt_s == ST_HOLD);
            arb_busy_r <= (state_nxt_s == ST_SCAN);
            if (load_out_s) begin
                arb_id_r   <= win_id_s;
                arb_prio_r <= win_prio_s;
            end else begin
                arb_id_r   <= arb_id_r;
                arb_prio_r <= arb_prio_r;
            end
        end
    end

    assign bus.arb_vld  = arb_vld_r;
    assign bus.arb_busy = arb_busy_r;
    assign bus.arb_id   = arb_id_r;
    assign bus.arb_prio = arb_prio_r;

`ifdef PA_CLIC_ARB_ONEHOT_EN
    logic [NUM-1:0] arb_onehot_r;

    // Load the one-hot copy alongside arb_id, and clear it whenever the result is not valid.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            arb_onehot_r <= '0;
        end else if (load_out_s) begin
            arb_onehot_r <= {{NUM-1{1'b0}}, 1'b1} << win_id_s;
        end else if (state_nxt_s != ST_HOLD) begin
            arb_onehot_r <= '0;
        end else begin
            arb_onehot_r <= arb_onehot_r;
        end
    end

    assign bus.arb_onehot = arb_onehot_r;
`else
    assign bus.arb_onehot = '0;
`endif

endmodule

// File: tb/tb_pa_clic_arb_scan.sv
// Bench for pa_clic_arb_scan (NUM=64, GROUP=8).
// Table-driven vectors feed a scoreboard queue, followed by hand-written multi-cycle sequences.
module tb_pa_clic_arb_scan;
    localparam int NUM      = 64;
    localparam int ID_W     = 6;
    localparam int PRIO_W   = 8;
    localparam int GROUP    = 8;
    localparam int SCAN_LEN = NUM / GROUP;
    localparam int BUDGET   = 3 * (SCAN_LEN + 1);

    logic forever_cpuclk;
    logic cpurst;

    pa_clic_arb_scan_if #(.NUM(NUM), .ID_W(ID_W), .PRIO_W(PRIO_W)) bus ();

    pa_clic_arb_scan #(.NUM(NUM), .ID_W(ID_W), .PRIO_W(PRIO_W), .GROUP(GROUP)) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .bus            (bus)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    typedef struct {
        logic [NUM-1:0]        pend;
        logic [PRIO_W*NUM-1:0] prio;
        logic [PRIO_W-1:0]     thresh;
        bit                    exp_vld;
        logic [ID_W-1:0]       exp_id;
        logic [PRIO_W-1:0]     exp_prio;
    } vec_t;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [PRIO_W-1:0] prio;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [NUM-1:0] onehot_of(input logic [ID_W-1:0] id);
        logic [NUM-1:0] v;
        v = '0;
`ifdef PA_CLIC_ARB_ONEHOT_EN
        v[id] = 1'b1;
`endif
        return v;
    endfunction

    // Random background priorities; only the sources marked pending matter.
    function automatic logic [PRIO_W*NUM-1:0] bg_prio();
        logic [PRIO_W*NUM-1:0] v;
        for (int i = 0; i < NUM; i++) v[PRIO_W*i +: PRIO_W] = PRIO_W'($urandom_range(255));
        return v;
    endfunction

    function automatic logic [PRIO_W*NUM-1:0] set_p(input logic [PRIO_W*NUM-1:0] v,
                                                    input int idx, input int p);
        logic [PRIO_W*NUM-1:0] r;
        r = v;
        r[PRIO_W*idx +: PRIO_W] = PRIO_W'(p);
        return r;
    endfunction

    task automatic add_vec(input logic [NUM-1:0] pend, input logic [PRIO_W*NUM-1:0] prio,
                           input int thr, input bit v, input int id, input int p);
        vec_t x;
        x.pend = pend; x.prio = prio; x.thresh = PRIO_W'(thr);
        x.exp_vld = v; x.exp_id = ID_W'(id); x.exp_prio = PRIO_W'(p);
        vecs.push_back(x);
    endtask

    // Advance one edge at a time until arb_vld rises or the budget runs out.
    task automatic wait_vld(input int budget, output int edges, output int busy_cnt, output bit got);
        edges = 0; busy_cnt = 0; got = 1'b0;
        while (edges < budget && !got) begin
            @(posedge forever_cpuclk); #1;
            edges++;
            if (bus.arb_vld) got = 1'b1;
            else if (bus.arb_busy) busy_cnt++;
        end
    endtask

    task automatic do_ack();
        @(negedge forever_cpuclk);
        bus.arb_en  = 1'b0;
        bus.arb_ack = 1'b1;
        @(posedge forever_cpuclk); #1;
        check("ack_clears_vld", 64'(bus.arb_vld), 64'd0);
        @(negedge forever_cpuclk);
        bus.arb_ack = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int   edges, busy_cnt;
        bit   got;
        exp_t e;
        @(negedge forever_cpuclk);
        bus.int_pend_vec = v.pend;
        bus.int_prio_vec = v.prio;
        bus.int_thresh   = v.thresh;
        bus.arb_en       = 1'b1;
        if (v.exp_vld) begin
            e.id = v.exp_id; e.prio = v.exp_prio;
            exp_q.push_back(e);
        end
        wait_vld(BUDGET, edges, busy_cnt, got);
        if (v.exp_vld) begin
            check($sformatf("v%0d_vld_timeout", n), 64'(got), 64'd1);
            if (got && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("v%0d_id", n), 64'(bus.arb_id), 64'(e.id));
                check($sformatf("v%0d_prio", n), 64'(bus.arb_prio), 64'(e.prio));
                check($sformatf("v%0d_latency", n), 64'(edges), 64'(SCAN_LEN + 1));
                check($sformatf("v%0d_busy_cycles", n), 64'(busy_cnt), 64'(SCAN_LEN));
                check($sformatf("v%0d_onehot", n), 64'(bus.arb_onehot), 64'(onehot_of(e.id)));
            end
            if (got) begin
                do_ack();
            end else begin
                bus.arb_en = 1'b0;
                repeat (SCAN_LEN + 2) @(posedge forever_cpuclk);
            end
        end else begin
            check($sformatf("v%0d_no_vld", n), 64'(got), 64'd0);
            check($sformatf("v%0d_rescan_busy", n), 64'(busy_cnt), 64'(3 * SCAN_LEN));
            if (got) begin
                do_ack();
            end else begin
                @(negedge forever_cpuclk);
                bus.arb_en = 1'b0;
                repeat (2) @(posedge forever_cpuclk);
            end
        end
        check($sformatf("v%0d_sb_empty", n), 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [PRIO_W*NUM-1:0] p;
        logic [NUM-1:0]        pd;
        int                    edges, busy_cnt, fails;
        bit                    got;

        // Vector table.
        p = set_p(bg_prio(), 37, 5);             pd = '0; pd[37] = 1'b1;
        add_vec(pd, p, 2, 1'b1, 37, 5);
        p = set_p(set_p(set_p(bg_prio(), 3, 7), 40, 9), 41, 9);
        pd = '0; pd[3] = 1'b1; pd[40] = 1'b1; pd[41] = 1'b1;
        add_vec(pd, p, 0, 1'b1, 40, 9);
        p = set_p(set_p(set_p(bg_prio(), 3, 9), 40, 9), 41, 9);
        add_vec(pd, p, 0, 1'b1, 3, 9);
        p = set_p(bg_prio(), 10, 4);             pd = '0; pd[10] = 1'b1;
        add_vec(pd, p, 4, 1'b0, 0, 0);
        add_vec(pd, p, 3, 1'b1, 10, 4);
        p = set_p(bg_prio(), 63, 200);           pd = '0; pd[63] = 1'b1;
        add_vec(pd, p, 0, 1'b1, 63, 200);
        p = set_p(bg_prio(), 0, 1);              pd = '0; pd[0] = 1'b1;
        add_vec(pd, p, 0, 1'b1, 0, 1);
        p = set_p(set_p(bg_prio(), 7, 3), 8, 3); pd = '0; pd[7] = 1'b1; pd[8] = 1'b1;
        add_vec(pd, p, 1, 1'b1, 7, 3);
        add_vec('0, bg_prio(), 0, 1'b0, 0, 0);
        p = set_p(set_p(bg_prio(), 5, 255), 60, 255); pd = '0; pd[5] = 1'b1; pd[60] = 1'b1;
        add_vec(pd, p, 254, 1'b1, 5, 255);
        p = set_p(bg_prio(), 20, 0);             pd = '0; pd[20] = 1'b1;
        add_vec(pd, p, 0, 1'b0, 0, 0);
        p = set_p(set_p(bg_prio(), 20, 0), 50, 1); pd[50] = 1'b1;
        add_vec(pd, p, 0, 1'b1, 50, 1);

        // Reset state.
        cpurst = 1'b1;
        bus.arb_en = 1'b0; bus.arb_ack = 1'b0;
        bus.int_pend_vec = '0; bus.int_prio_vec = '0; bus.int_thresh = '0;
        repeat (2) @(posedge forever_cpuclk);
        #1;
        check("rst_vld", 64'(bus.arb_vld), 64'd0);
        check("rst_busy", 64'(bus.arb_busy), 64'd0);
        check("rst_id", 64'(bus.arb_id), 64'd0);
        check("rst_prio", 64'(bus.arb_prio), 64'd0);
        check("rst_onehot", 64'(bus.arb_onehot), 64'd0);
        @(negedge forever_cpuclk);
        cpurst = 1'b0;
        repeat (2) @(posedge forever_cpuclk);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Handshake: hold without ack; arb_en drop and input changes are ignored.
        @(negedge forever_cpuclk);
        bus.int_pend_vec = '0; bus.int_pend_vec[37] = 1'b1;
        bus.int_prio_vec = set_p(bg_prio(), 37, 5);
        bus.int_thresh = 8'd2; bus.arb_en = 1'b1;
        wait_vld(BUDGET, edges, busy_cnt, got);
        check("hs_vld", 64'(got), 64'd1);
        fails = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge forever_cpuclk);
            if (c == 3) bus.arb_en = 1'b0;
            if (c == 6) begin bus.int_pend_vec = '1; bus.int_prio_vec = '1; end
            @(posedge forever_cpuclk); #1;
            if (!(bus.arb_vld === 1'b1 && bus.arb_id === 6'd37 && bus.arb_prio === 8'd5)) fails++;
        end
        check("hs_stable_20", 64'(fails), 64'd0);
        check("hs_id", 64'(bus.arb_id), 64'd37);
        do_ack();
        check("hs_idle_busy", 64'(bus.arb_busy), 64'd0);

        // Abort: arb_en drops after the fourth scan cycle.
        @(negedge forever_cpuclk);
        bus.int_pend_vec = '0; bus.int_pend_vec[37] = 1'b1;
        bus.int_prio_vec = set_p(bg_prio(), 37, 5);
        bus.arb_en = 1'b1;
        repeat (4) @(posedge forever_cpuclk);
        #1;
        check("abort_busy_before", 64'(bus.arb_busy), 64'd1);
        @(negedge forever_cpuclk);
        bus.arb_en = 1'b0;
        @(posedge forever_cpuclk); #1;
        check("abort_busy_after", 64'(bus.arb_busy), 64'd0);
        wait_vld(2 * SCAN_LEN, edges, busy_cnt, got);
        check("abort_no_vld", 64'(got), 64'd0);

        // Live sampling: a source cleared after its group was scanned still wins.
        // The threshold is taken from the last scan cycle only.
        @(negedge forever_cpuclk);
        bus.int_pend_vec = '0; bus.int_pend_vec[5] = 1'b1;
        bus.int_prio_vec = set_p(bg_prio(), 5, 9);
        bus.int_thresh = 8'd200; bus.arb_en = 1'b1;
        repeat (2) @(posedge forever_cpuclk);
        @(negedge forever_cpuclk);
        bus.int_pend_vec = '0; bus.int_thresh = 8'd2;
        wait_vld(BUDGET, edges, busy_cnt, got);
        check("live_vld", 64'(got), 64'd1);
        check("live_id", 64'(bus.arb_id), 64'd5);
        check("live_prio", 64'(bus.arb_prio), 64'd9);

        // Asynchronous reset while in HOLD.
        #2 cpurst = 1'b1;
        #1;
        check("rst_hold_vld", 64'(bus.arb_vld), 64'd0);
        check("rst_hold_id", 64'(bus.arb_id), 64'd0);
        check("rst_hold_prio", 64'(bus.arb_prio), 64'd0);
        check("rst_hold_onehot", 64'(bus.arb_onehot), 64'd0);
        @(negedge forever_cpuclk);
        cpurst = 1'b0;

        // Asynchronous reset in the middle of a scan.
        @(negedge forever_cpuclk);
        bus.int_pend_vec = '0; bus.int_pend_vec[37] = 1'b1;
        bus.int_thresh = 8'd2; bus.arb_en = 1'b1;
        repeat (3) @(posedge forever_cpuclk);
        #2;
        check("pre_rst_busy", 64'(bus.arb_busy), 64'd1);
        cpurst = 1'b1;
        #1;
        check("rst_scan_busy", 64'(bus.arb_busy), 64'd0);
        check("rst_scan_vld", 64'(bus.arb_vld), 64'd0);
        check("rst_scan_id", 64'(bus.arb_id), 64'd0);
        @(negedge forever_cpuclk);
        bus.arb_en = 1'b0;
        cpurst = 1'b0;
        repeat (2) @(posedge forever_cpuclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
